// File: rtl/board_pkg.sv
// board_pkg: shared cell/FSM types, board size and the 8 winning lines of the 3x3 board
package board_pkg;
  typedef enum logic [1:0] {EMPTY = 2'b00, X = 2'b01, O = 2'b10} cell_t;
  typedef enum logic [1:0] {IDLE, CHECK, WRITE, EVAL} fsm_t;
  localparam int NUM_CELLS = 9;
  localparam logic [0:7][0:2][3:0] WIN_LINES = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };
  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] i);
    return b[2*i +: 2];
  endfunction
endpackage

// File: rtl/board_marker_win_checker.sv
// win_checker: combinational test whether player owns any of the 8 board lines
//   board  in 18 : packed board, cell i at [2i+1:2i]
//   player in 2  : 01 X, 10 O
//   win    out 1 : player holds a complete line
module win_checker
  import board_pkg::*;
(
  input  logic [17:0] board,
  input  logic [1:0]  player,
  output logic        win
);
  always_comb begin
    win = 1'b0;
    for (int l = 0; l < 8; l++)
      win = win | (cell_at(board, WIN_LINES[l][0]) == player &&
                   cell_at(board, WIN_LINES[l][1]) == player &&
                   cell_at(board, WIN_LINES[l][2]) == player);
  end
endmodule

// File: rtl/board_marker.sv
// board_marker: validates and marks tic-tac-toe moves strobed by Ready, tracks turn, win, draw
//   clk, reset (sync, active-high)
//   pos in 4, Ready in 1 : cell selection and its strobe (rising edge triggers)
//   board out 18 : cell i at [2i+1:2i], 00 empty / 01 X / 10 O
//   turn out 2, busy out 1, move_ok/move_err out 1 (one-cycle pulses)
//   winner out 2, game_over out 1 (sticky)
//   Macro BOARD_WIN_DETECT_EN enables the 8-line win check; without it only a full board ends the game
module board_marker
  import board_pkg::*;
#(
  parameter logic [1:0] FIRST_PLAYER = 2'b01
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  pos,
  input  logic        Ready,
  output logic [17:0] board,
  output logic [1:0]  turn,
  output logic        busy,
  output logic        move_ok,
  output logic        move_err,
  output logic [1:0]  winner,
  output logic        game_over
);
  fsm_t state, next;
  logic ready_d, trig, bad, win;
  logic [3:0] pos_q, move_cnt;
  assign busy = state != IDLE;
  assign trig = Ready && !ready_d && state == IDLE && !game_over;
  // out-of-range positions short the OR before the cell contents matter
  assign bad = pos_q >= 4'(NUM_CELLS) || cell_at(board, pos_q) != EMPTY;
`ifdef BOARD_WIN_DETECT_EN
  win_checker u_win (.board(board), .player(turn), .win(win));
`else
  assign win = 1'b0;
`endif
  always_comb next = state == IDLE  ? (trig ? CHECK : IDLE) :
                     state == CHECK ? (bad ? IDLE : WRITE) :
                     state == WRITE ? EVAL : IDLE;
  always_ff @(posedge clk)
    state <= reset ? IDLE : next;
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_d   <= 1'b0;
      pos_q     <= '0;
      board     <= '0;
      turn      <= FIRST_PLAYER;
      move_cnt  <= '0;
      move_ok   <= 1'b0;
      move_err  <= 1'b0;
      winner    <= '0;
      game_over <= 1'b0;
    end else begin
      ready_d  <= Ready;
      move_ok  <= state == EVAL;
      move_err <= state == CHECK && bad;
      if (trig) pos_q <= pos;
      if (state == WRITE) begin
        for (int i = 0; i < NUM_CELLS; i++)
          if (pos_q == 4'(i)) board[2*i +: 2] <= turn;
        move_cnt <= move_cnt == 4'(NUM_CELLS) ? move_cnt : move_cnt + 4'd1;
      end
      if (state == EVAL) begin
        if (win) begin
          winner    <= turn;
          game_over <= 1'b1;
        end else if (move_cnt == 4'(NUM_CELLS))
          game_over <= 1'b1;
        else
          turn <= turn == X ? O : X;
      end
    end
  end
endmodule

// File: tb/tb_board_marker.sv
// tb_board_marker: table vectors, corner sequences and random games against a cell-array model
module tb_board_marker;
  logic clk = 1'b0;
  logic reset, Ready;
  logic [3:0] pos;
  logic [17:0] board;
  logic [1:0] turn, winner;
  logic busy, move_ok, move_err, game_over;
  int n_tests = 0, n_fail = 0;
`ifdef BOARD_WIN_DETECT_EN
  localparam bit WIN_EN = 1'b1;
`else
  localparam bit WIN_EN = 1'b0;
`endif
  board_marker dut (
    .clk(clk), .reset(reset), .pos(pos), .Ready(Ready), .board(board), .turn(turn),
    .busy(busy), .move_ok(move_ok), .move_err(move_err), .winner(winner), .game_over(game_over)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit          rst;
    logic [3:0]  pos;
    int          ok_at;
    int          err_at;
    logic [17:0] board;
    logic [1:0]  turn;
    logic [1:0]  winner;
    logic        over;
  } vec_t;
  vec_t vecs[10];
  int m_cells[9];
  int m_turn, m_cnt, m_win;
  bit m_over;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic bit owns(input int p);
    for (int k = 0; k < 3; k++) begin
      if (m_cells[3*k] == p && m_cells[3*k+1] == p && m_cells[3*k+2] == p) return 1'b1;
      if (m_cells[k] == p && m_cells[k+3] == p && m_cells[k+6] == p) return 1'b1;
    end
    return m_cells[4] == p && ((m_cells[0] == p && m_cells[8] == p) || (m_cells[2] == p && m_cells[6] == p));
  endfunction
  function automatic logic [17:0] m_board();
    logic [17:0] b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_cells[i]);
    return b;
  endfunction
  task automatic model_move(input int p, output int ok_at, output int err_at);
    ok_at = -1;
    err_at = -1;
    if (m_over) return;
    if (p >= 9 || m_cells[p] != 0) begin
      err_at = 2;
      return;
    end
    m_cells[p] = m_turn;
    m_cnt++;
    if (WIN_EN && owns(m_turn)) begin
      m_win = m_turn;
      m_over = 1'b1;
    end else if (m_cnt == 9) m_over = 1'b1;
    else m_turn = 3 - m_turn;
    ok_at = 4;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    Ready = 1'b0;
    pos = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_cells = '{default: 0};
    m_turn = 1;
    m_cnt = 0;
    m_win = 0;
    m_over = 1'b0;
  endtask
  task automatic check_reset(input string n);
    chk({n, "_board"}, board, 0);
    chk({n, "_turn"}, turn, 1);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_ok"}, move_ok, 0);
    chk({n, "_err"}, move_err, 0);
    chk({n, "_winner"}, winner, 0);
    chk({n, "_over"}, game_over, 0);
  endtask
  // one-cycle Ready pulse, then record the sample index (1..6) of each pulse; 99 flags a repeat
  task automatic do_move(input logic [3:0] p, output int ok_at, output int err_at);
    ok_at = -1;
    err_at = -1;
    @(negedge clk);
    pos = p;
    Ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      Ready = 1'b0;
      if (move_ok) ok_at = ok_at == -1 ? c : 99;
      if (move_err) err_at = err_at == -1 ? c : 99;
    end
  endtask
  task automatic play(input string n, input int p);
    int eo, ee, ao, ae;
    model_move(p, eo, ee);
    do_move(4'(p), ao, ae);
    chk($sformatf("%s_p%0d_ok_at", n, p), ao, eo);
    chk($sformatf("%s_p%0d_err_at", n, p), ae, ee);
    chk($sformatf("%s_p%0d_board", n, p), board, m_board());
    chk($sformatf("%s_p%0d_turn", n, p), turn, m_turn);
    chk($sformatf("%s_p%0d_winner", n, p), winner, m_win);
    chk($sformatf("%s_p%0d_over", n, p), game_over, m_over);
  endtask
  initial begin
    int ao, ae, okc, pulses;
    int draw_seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    reset = 1'b1;
    Ready = 1'b0;
    pos = '0;
    vecs[0] = '{1'b1, 4'd4,  4, -1, 18'h100, 2'd2, 2'd0, 1'b0};
    vecs[1] = '{1'b0, 4'd4, -1,  2, 18'h100, 2'd2, 2'd0, 1'b0};
    vecs[2] = '{1'b0, 4'd9, -1,  2, 18'h100, 2'd2, 2'd0, 1'b0};
    vecs[3] = '{1'b0, 4'd15, -1, 2, 18'h100, 2'd2, 2'd0, 1'b0};
    vecs[4] = '{1'b1, 4'd0,  4, -1, 18'h001, 2'd2, 2'd0, 1'b0};
    vecs[5] = '{1'b0, 4'd3,  4, -1, 18'h081, 2'd1, 2'd0, 1'b0};
    vecs[6] = '{1'b0, 4'd1,  4, -1, 18'h085, 2'd2, 2'd0, 1'b0};
    vecs[7] = '{1'b0, 4'd4,  4, -1, 18'h285, 2'd1, 2'd0, 1'b0};
`ifdef BOARD_WIN_DETECT_EN
    vecs[8] = '{1'b0, 4'd2,  4, -1, 18'h295, 2'd1, 2'd1, 1'b1};
    vecs[9] = '{1'b0, 4'd8, -1, -1, 18'h295, 2'd1, 2'd1, 1'b1};
`else
    vecs[8] = '{1'b0, 4'd2,  4, -1, 18'h295, 2'd2, 2'd0, 1'b0};
    vecs[9] = '{1'b0, 4'd8,  4, -1, 18'h20295, 2'd1, 2'd0, 1'b0};
`endif
    do_reset();
    check_reset("reset");
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].rst) do_reset();
      do_move(vecs[i].pos, ao, ae);
      chk($sformatf("v%0d_ok_at", i), ao, vecs[i].ok_at);
      chk($sformatf("v%0d_err_at", i), ae, vecs[i].err_at);
      chk($sformatf("v%0d_board", i), board, vecs[i].board);
      chk($sformatf("v%0d_turn", i), turn, vecs[i].turn);
      chk($sformatf("v%0d_winner", i), winner, vecs[i].winner);
      chk($sformatf("v%0d_over", i), game_over, vecs[i].over);
    end
    do_reset();
    @(negedge clk);
    pos = 4'd0;
    Ready = 1'b1;
    okc = 0;
    repeat (10) begin
      @(negedge clk);
      if (move_ok) okc++;
    end
    Ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (move_ok) okc++;
    end
    chk("hold_ok_cnt", okc, 1);
    chk("hold_board", board, 18'h1);
    chk("hold_turn", turn, 2);
    @(negedge clk);
    pos = 4'd5;
    Ready = 1'b1;
    okc = 0;
    @(negedge clk);
    Ready = 1'b0;
    chk("busy_flag", busy, 1);
    @(negedge clk);
    pos = 4'd6;
    Ready = 1'b1;
    @(negedge clk);
    Ready = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (move_ok) okc++;
    end
    chk("busy_ok_cnt", okc, 1);
    chk("busy_board", board, 18'h801);
    chk("busy_turn", turn, 1);
    chk("busy_idle", busy, 0);
    do_reset();
    foreach (draw_seq[i]) play("draw", draw_seq[i]);
    chk("draw_over", game_over, 1);
    chk("draw_winner", winner, 0);
    play("draw_after", 0);
    do_reset();
    @(negedge clk);
    pos = 4'd4;
    Ready = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 1);
    reset = 1'b1;
    Ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (move_ok || move_err) pulses++;
    end
    chk("abort_pulses", pulses, 0);
    check_reset("abort");
    for (int g = 0; g < 8; g++) begin
      do_reset();
      for (int m = 0; m < 25 && !m_over; m++)
        play($sformatf("rnd%0d", g), $urandom_range(0, 3) == 0 ? $urandom_range(9, 15) : $urandom_range(0, 8));
      play($sformatf("rnd%0d_end", g), $urandom_range(0, 8));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
